// File: rtl/wb_port_arbiter_if.sv
// Writeback request/port bundle shared by the two requesters, Decode and the arbiter.
interface wb_port_arbiter_if #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned VECTOR_SIZE   = 6,
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned COUNT_WIDTH   = 8
);
   // requester A (execute result)
   logic                                   aValid;
   logic                                   aReady;
   logic                                   aIsVector;
   logic [ADDRESS_WIDTH-1:0]               aAddress;
   logic [DATA_WIDTH-1:0]                  aScalarData;
   logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] aVectorData;

   // requester B (memory load result)
   logic                                   bValid;
   logic                                   bReady;
   logic                                   bIsVector;
   logic [ADDRESS_WIDTH-1:0]               bAddress;
   logic [DATA_WIDTH-1:0]                  bScalarData;
   logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] bVectorData;

   // Decode side
   logic [ADDRESS_WIDTH-1:0]               reg1Address;
   logic [ADDRESS_WIDTH-1:0]               reg2Address;
   logic                                   writeEnableScalar;
   logic                                   writeEnableVector;
   logic [ADDRESS_WIDTH-1:0]               writeAddress;
   logic [DATA_WIDTH-1:0]                  writeScalarData;
   logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] writeVectorData;
   logic                                   stallDecode;
   logic [COUNT_WIDTH-1:0]                 contentionCount;

   // Arbiter view
   modport slave (
      input  aValid, aIsVector, aAddress, aScalarData, aVectorData,
      input  bValid, bIsVector, bAddress, bScalarData, bVectorData,
      input  reg1Address, reg2Address,
      output aReady, bReady,
      output writeEnableScalar, writeEnableVector, writeAddress,
      output writeScalarData, writeVectorData, stallDecode, contentionCount
   );

   // Requester / Decode view
   modport master (
      output aValid, aIsVector, aAddress, aScalarData, aVectorData,
      output bValid, bIsVector, bAddress, bScalarData, bVectorData,
      output reg1Address, reg2Address,
      input  aReady, bReady,
      input  writeEnableScalar, writeEnableVector, writeAddress,
      input  writeScalarData, writeVectorData, stallDecode, contentionCount
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between execute (A) and load (B) results.
module wb_port_arbiter #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned VECTOR_SIZE   = 6,
   parameter int unsigned ADDRESS_WIDTH = 4,
   parameter int unsigned COUNT_WIDTH   = 8
) (
   input  logic             clock,
   input  logic             reset,
   wb_port_arbiter_if.slave bus
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   logic grant_a_c;
   logic grant_b_c;
   logic both_valid_c;
   logic stall_a_c;
   logic stall_b_c;

   logic                                   last_grant_q, last_grant_d;
   logic                                   we_scalar_q, we_scalar_d;
   logic                                   we_vector_q, we_vector_d;
   logic [ADDRESS_WIDTH-1:0]               addr_q, addr_d;
   logic [DATA_WIDTH-1:0]                  sdata_q, sdata_d;
   logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] vdata_q, vdata_d;
   logic [COUNT_WIDTH-1:0]                 count_q, count_d;

   // Grant: sole requester wins; on a tie the one not granted last time wins; none while in reset
   always_comb begin
      grant_a_c    = 1'b0;
      grant_b_c    = 1'b0;
      both_valid_c = bus.aValid & bus.bValid;
      if (!reset) begin
         if (both_valid_c) begin
            grant_a_c = last_grant_q;
            grant_b_c = ~last_grant_q;
         end else begin
            grant_a_c = bus.aValid;
            grant_b_c = bus.bValid;
         end
      end
   end

   // Stall Decode when a source register has a write still waiting for the port (type-agnostic match)
   always_comb begin
      stall_a_c = bus.aValid & ~grant_a_c &
                  ((bus.aAddress == bus.reg1Address) | (bus.aAddress == bus.reg2Address));
      stall_b_c = bus.bValid & ~grant_b_c &
                  ((bus.bAddress == bus.reg1Address) | (bus.bAddress == bus.reg2Address));
   end

   // Next state: load the write port from the winner, hold address/data otherwise
   always_comb begin
      last_grant_d = last_grant_q;
      we_scalar_d  = 1'b0;
      we_vector_d  = 1'b0;
      addr_d       = addr_q;
      sdata_d      = sdata_q;
      vdata_d      = vdata_q;
      count_d      = count_q;
      if (grant_a_c) begin
         last_grant_d = 1'b0;
         we_scalar_d  = ~bus.aIsVector;
         we_vector_d  = bus.aIsVector;
         addr_d       = bus.aAddress;
         sdata_d      = bus.aScalarData;
         vdata_d      = bus.aVectorData;
      end else if (grant_b_c) begin
         last_grant_d = 1'b1;
         we_scalar_d  = ~bus.bIsVector;
         we_vector_d  = bus.bIsVector;
         addr_d       = bus.bAddress;
         sdata_d      = bus.bScalarData;
         vdata_d      = bus.bVectorData;
      end
      if (both_valid_c && (count_q != COUNT_MAX)) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end
   end

   // State and write-port registers; reset makes A win the first tie
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         we_scalar_q  <= 1'b0;
         we_vector_q  <= 1'b0;
         addr_q       <= '0;
         sdata_q      <= '0;
         vdata_q      <= '0;
         count_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         we_scalar_q  <= we_scalar_d;
         we_vector_q  <= we_vector_d;
         addr_q       <= addr_d;
         sdata_q      <= sdata_d;
         vdata_q      <= vdata_d;
         count_q      <= count_d;
      end
   end

   assign bus.aReady            = grant_a_c;
   assign bus.bReady            = grant_b_c;
   assign bus.stallDecode       = stall_a_c | stall_b_c;
   assign bus.writeEnableScalar = we_scalar_q;
   assign bus.writeEnableVector = we_vector_q;
   assign bus.writeAddress      = addr_q;
   assign bus.writeScalarData   = sdata_q;
   assign bus.writeVectorData   = vdata_q;
   assign bus.contentionCount   = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: grants, write-port latency, hazards, saturation, reset.
module tb_wb_port_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned VS = 6;
   localparam int unsigned AW = 4;
   localparam int unsigned CW = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int compared   = 0;
   int mismatched = 0;

   wb_port_arbiter_if #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

   wb_port_arbiter #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .ADDRESS_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.aValid = 1'b0;
      bus.bValid = 1'b0;
   endtask

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.aValid      = 1'b0;  bus.bValid      = 1'b0;
      bus.aIsVector   = 1'b0;  bus.bIsVector   = 1'b0;
      bus.aAddress    = '0;    bus.bAddress    = '0;
      bus.aScalarData = '0;    bus.bScalarData = '0;
      bus.aVectorData = '0;    bus.bVectorData = '0;
      bus.reg1Address = 4'hF;  bus.reg2Address = 4'hF;

      // reset state, with A pending so stall is visible during reset
      tick();
      bus.aValid = 1'b1; bus.aIsVector = 1'b0; bus.aAddress = 4'd3; bus.aScalarData = 8'h5A;
      bus.reg1Address = 4'd3;
      tick();
      chk("rst_we_s",  64'(bus.writeEnableScalar), 64'(0));
      chk("rst_we_v",  64'(bus.writeEnableVector), 64'(0));
      chk("rst_addr",  64'(bus.writeAddress), 64'(0));
      chk("rst_sdata", 64'(bus.writeScalarData), 64'(0));
      chk("rst_vdata", 64'(bus.writeVectorData), 64'(0));
      chk("rst_count", 64'(bus.contentionCount), 64'(0));
      chk("rst_lastg", 64'(dut.last_grant_q), 64'(1));
      chk("rst_aready", 64'(bus.aReady), 64'(0));
      chk("rst_stall", 64'(bus.stallDecode), 64'(1));

      // single requester A, held across reset release
      reset = 1'b0;
      #1;
      chk("single_aready", 64'(bus.aReady), 64'(1));
      chk("single_bready", 64'(bus.bReady), 64'(0));
      chk("single_stall",  64'(bus.stallDecode), 64'(0));
      tick();
      idle();
      chk("single_we_s",  64'(bus.writeEnableScalar), 64'(1));
      chk("single_we_v",  64'(bus.writeEnableVector), 64'(0));
      chk("single_addr",  64'(bus.writeAddress), 64'(3));
      chk("single_sdata", 64'(bus.writeScalarData), 64'(8'h5A));
      tick();
      chk("single_idle_we_s", 64'(bus.writeEnableScalar), 64'(0));
      chk("single_idle_we_v", 64'(bus.writeEnableVector), 64'(0));
      chk("single_hold_addr", 64'(bus.writeAddress), 64'(3));
      chk("single_hold_sdata", 64'(bus.writeScalarData), 64'(8'h5A));
      chk("single_count", 64'(bus.contentionCount), 64'(0));

      // tie after reset: A first, B next cycle
      reset = 1'b1; tick(); reset = 1'b0;
      bus.aValid = 1'b1; bus.aIsVector = 1'b0; bus.aAddress = 4'd2; bus.aScalarData = 8'h11;
      bus.bValid = 1'b1; bus.bIsVector = 1'b1; bus.bAddress = 4'd5;
      bus.bVectorData = 48'h0102_0304_0506;
      bus.reg1Address = 4'd5; bus.reg2Address = 4'd0;
      #1;
      chk("tie_aready", 64'(bus.aReady), 64'(1));
      chk("tie_bready", 64'(bus.bReady), 64'(0));
      chk("tie_stall",  64'(bus.stallDecode), 64'(1));
      tick();
      bus.aValid = 1'b0;
      #1;
      chk("tie_n1_we_s",  64'(bus.writeEnableScalar), 64'(1));
      chk("tie_n1_addr",  64'(bus.writeAddress), 64'(2));
      chk("tie_n1_sdata", 64'(bus.writeScalarData), 64'(8'h11));
      chk("tie_n1_bready", 64'(bus.bReady), 64'(1));
      chk("tie_n1_stall", 64'(bus.stallDecode), 64'(0));
      chk("tie_n1_count", 64'(bus.contentionCount), 64'(1));
      tick();
      idle();
      chk("tie_n2_we_v",  64'(bus.writeEnableVector), 64'(1));
      chk("tie_n2_we_s",  64'(bus.writeEnableScalar), 64'(0));
      chk("tie_n2_addr",  64'(bus.writeAddress), 64'(5));
      chk("tie_n2_vdata", 64'(bus.writeVectorData), 64'(48'h0102_0304_0506));
      chk("tie_n2_count", 64'(bus.contentionCount), 64'(1));

      // continuous contention from reset: strict A,B alternation
      reset = 1'b1; tick(); reset = 1'b0;
      bus.aValid = 1'b1; bus.aIsVector = 1'b0; bus.aAddress = 4'd1; bus.aScalarData = 8'hA1;
      bus.bValid = 1'b1; bus.bIsVector = 1'b1; bus.bAddress = 4'd6;
      bus.bVectorData = 48'hB0B1_B2B3_B4B5;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("cont_aready", 64'(bus.aReady), 64'(i % 2 == 0));
         chk("cont_bready", 64'(bus.bReady), 64'(i % 2 == 1));
         tick();
         chk("cont_we_s", 64'(bus.writeEnableScalar), 64'(i % 2 == 0));
         chk("cont_we_v", 64'(bus.writeEnableVector), 64'(i % 2 == 1));
         chk("cont_addr", 64'(bus.writeAddress), (i % 2 == 0) ? 64'(1) : 64'(6));
      end
      idle();
      chk("cont_count", 64'(bus.contentionCount), 64'(10));

      // hazard: B to addr 4 waits while A wins; last grant was B so A wins the tie
      bus.aValid = 1'b1; bus.aIsVector = 1'b0; bus.aAddress = 4'd7;
      bus.bValid = 1'b1; bus.bIsVector = 1'b0; bus.bAddress = 4'd4;
      bus.reg1Address = 4'd4; bus.reg2Address = 4'd0;
      #1;
      chk("haz_aready", 64'(bus.aReady), 64'(1));
      chk("haz_stall",  64'(bus.stallDecode), 64'(1));
      tick();
      bus.aValid = 1'b0;
      #1;
      chk("haz_bready", 64'(bus.bReady), 64'(1));
      chk("haz_stall_clear", 64'(bus.stallDecode), 64'(0));
      tick();
      idle();
      chk("haz_count", 64'(bus.contentionCount), 64'(11));

      // saturation
      bus.aValid = 1'b1; bus.bValid = 1'b1;
      repeat (300) tick();
      chk("sat_count", 64'(bus.contentionCount), 64'(255));
      repeat (5) tick();
      chk("sat_hold", 64'(bus.contentionCount), 64'(255));
      idle();

      // reset in the write-port cycle of a vector write
      bus.bValid = 1'b1; bus.bIsVector = 1'b1; bus.bAddress = 4'd9;
      bus.bVectorData = 48'hDEAD_BEEF_CAFE;
      tick();
      bus.bValid = 1'b0;
      chk("mid_we_v", 64'(bus.writeEnableVector), 64'(1));
      chk("mid_vdata", 64'(bus.writeVectorData), 64'(48'hDEAD_BEEF_CAFE));
      reset = 1'b1;
      bus.aValid = 1'b1; bus.aIsVector = 1'b0; bus.aAddress = 4'd3; bus.aScalarData = 8'h77;
      bus.bValid = 1'b1; bus.bIsVector = 1'b1; bus.bAddress = 4'd8;
      #1;
      chk("mid_rst_aready", 64'(bus.aReady), 64'(0));
      chk("mid_rst_bready", 64'(bus.bReady), 64'(0));
      tick();
      chk("mid_rst_we_s",  64'(bus.writeEnableScalar), 64'(0));
      chk("mid_rst_we_v",  64'(bus.writeEnableVector), 64'(0));
      chk("mid_rst_addr",  64'(bus.writeAddress), 64'(0));
      chk("mid_rst_vdata", 64'(bus.writeVectorData), 64'(0));
      chk("mid_rst_sdata", 64'(bus.writeScalarData), 64'(0));
      chk("mid_rst_count", 64'(bus.contentionCount), 64'(0));
      chk("mid_rst_lastg", 64'(dut.last_grant_q), 64'(1));
      reset = 1'b0;
      #1;
      chk("post_rst_aready", 64'(bus.aReady), 64'(1));
      chk("post_rst_bready", 64'(bus.bReady), 64'(0));
      tick();
      bus.aValid = 1'b0;
      #1;
      chk("post_rst_we_s", 64'(bus.writeEnableScalar), 64'(1));
      chk("post_rst_addr", 64'(bus.writeAddress), 64'(3));
      chk("post_rst_bready2", 64'(bus.bReady), 64'(1));
      tick();
      idle();
      chk("post_rst_we_v", 64'(bus.writeEnableVector), 64'(1));
      chk("post_rst_addr2", 64'(bus.writeAddress), 64'(8));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port (scalar and vector files inside Decode) between two writeback requesters: the execute-stage result (requester A) and the memory-load result (requester B). It arbitrates round-robin, drives the registered write port, and raises a decode-stall flag when a source register read in Decode has a write still waiting for the port. It sits between the execute/memory stages and Decode.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one scalar/lane element
- VECTOR_SIZE, 6, lanes per vector register
- ADDRESS_WIDTH, 4, register address width
- COUNT_WIDTH, 8, width of the contention counter

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- aValid, bValid  in  1  requester has a pending write
- aReady, bReady  out  1  write accepted this cycle (combinational)
- aIsVector, bIsVector  in  1  1 = vector file, 0 = scalar file
- aAddress, bAddress  in  ADDRESS_WIDTH  destination register
- aScalarData, bScalarData  in  DATA_WIDTH  scalar payload
- aVectorData, bVectorData  in  VECTOR_SIZE x DATA_WIDTH  vector payload
- reg1Address, reg2Address  in  ADDRESS_WIDTH  Decode source addresses
- writeEnableScalar, writeEnableVector  out  1  to Decode write enables
- writeAddress  out  ADDRESS_WIDTH  to Decode
- writeScalarData  out  DATA_WIDTH  to Decode
- writeVectorData  out  VECTOR_SIZE x DATA_WIDTH  to Decode
- stallDecode  out  1  source operand has an unwritten pending write
- contentionCount  out  COUNT_WIDTH  saturating count of cycles with both requesters valid

## Operation
- One state bit lastGrant (0 = A, 1 = B). Reset value 1, so A wins the first tie.
- Grant rules: only aValid -> A; only bValid -> B; both -> the requester other than lastGrant; neither -> none.
- aReady = grant to A; bReady = grant to B. A ready is never asserted without the matching valid.
- On a grant, lastGrant takes the granted requester at the clock edge. With no grant it holds.
- Requesters must hold valid and payload stable until ready. The block does no buffering and never drops or merges writes.
- Output register on a grant loads:
  - writeAddress, writeScalarData and writeVectorData from the winner;
  - writeEnableVector = winner IsVector;
  - writeEnableScalar = !winner IsVector.
- With no grant, both enables are 0 next cycle. Address and data registers hold their last value.
- Both enables are never 1 in the same cycle.
- Same destination from both requesters: writes serialize in grant order; the second one wins in the register file.
- stallDecode (combinational) = (aValid & !aReady & aAddress matches reg1Address or reg2Address) OR (same for B).
  - Matching is on address only and ignores the scalar/vector type (conservative).
  - A write already in the output register does not stall. The register file writes on the falling edge, so Decode reads the new value in the same cycle.
- contentionCount increments when aValid & bValid and saturates at 2^COUNT_WIDTH-1.

## Timing
- Latency: a request accepted in cycle N (valid & ready) appears on the write port during cycle N+1. The register file commits it at the falling edge inside N+1.
- Throughput: one write per cycle. Under continuous contention, A and B alternate every cycle.
- Maximum wait for a valid requester: 1 cycle.
- Reset (synchronous, any cycle, including mid-contention), at the first rising edge with reset=1:
  - writeEnableScalar = writeEnableVector = 0;
  - writeAddress = 0; writeScalarData = 0; writeVectorData = 0;
  - lastGrant = 1; contentionCount = 0.
- While reset=1, aReady = bReady = 0, and stallDecode is still evaluated combinationally.
- A request that was valid but not accepted before reset is not lost: it is granted after reset deasserts if valid is still held.

## Test plan
- Single requester: aValid=1, aIsVector=0, aAddress=3, aScalarData=0x5A for 1 cycle -> aReady=1 same cycle. Next cycle writeEnableScalar=1, writeAddress=3, writeScalarData=0x5A. Following cycle both enables 0.
- Tie after reset: A (scalar, addr 2) and B (vector, addr 5) valid together -> cycle N: aReady=1, bReady=0. N+1: scalar write to 2 on the port, bReady=1. N+2: writeEnableVector=1, writeAddress=5. contentionCount=1.
- Continuous contention, 10 cycles, with both requesters re-presenting immediately -> grants alternate A,B,A,B… exactly. contentionCount=10. Never both enables high.
- Hazard: bValid=1 to addr 4 held while A wins, reg1Address=4 -> stallDecode=1 that cycle. Next cycle B is granted -> stallDecode=0.
- Saturation: COUNT_WIDTH=8, both valid for 300 cycles -> contentionCount=255 and holds.
- Reset mid-operation: assert reset during the write-port cycle of a vector write -> next edge both enables 0, outputs 0, lastGrant=1. Deassert with A and B both valid -> A granted first.
